// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the MEM/WB pipeline boundary.
//   - default control/data widths of the stage payload
//   - bit offsets of each architectural field inside the packed payload
//   - ResultSrc encodings and a small helper to build the control field
package pipe_pkg;

  localparam int CTRL_W_DEF = 3;
  localparam int DATA_W_DEF = 101;
  localparam int XLEN       = 32;

  // Control field layout: {RegWrite, ResultSrc[1:0]}
  localparam int REGWRITE_BIT  = 2;
  localparam int RESULTSRC_LSB = 0;
  localparam int RESULTSRC_W   = 2;

  // Data field layout: {ReadData, ALUResult, PCPlus4, Rd}
  localparam int RD_LSB        = 0;
  localparam int RD_W          = 5;
  localparam int PCPLUS4_LSB   = 5;
  localparam int ALURESULT_LSB = 37;
  localparam int READDATA_LSB  = 69;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  function automatic logic [CTRL_W_DEF-1:0] make_ctrl(input logic reg_write,
                                                      input result_src_e src);
    return {reg_write, src};
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// pipe_skid_entry: one payload slot (ctrl + data) with a valid flag.
// Ports:
//   clk, rst_n        clock / async active-low reset (clears everything)
//   flush             drops the entry and zeroes ctrl; data is kept
//   load              captures d_ctrl/d_data and marks the slot valid
//   unload            marks the slot empty (ignored when load is set)
//   d_ctrl, d_data    incoming payload
//   q_valid, q_ctrl, q_data   registered slot contents
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Slot state: flush beats load, load beats unload; data survives a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
      data_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
      ctrl_r  <= '0;
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= d_ctrl;
      data_r  <= d_data;
    end else if (unload) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign q_valid = valid_r;
  assign q_ctrl  = ctrl_r;
  assign q_data  = data_r;

endmodule

// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: elastic valid/ready pipeline register for the MEM->WB boundary.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   in_valid, in_ready          upstream handshake
//   in_ctrl, in_data            upstream payload
//   out_valid, out_ready        downstream handshake
//   out_ctrl, out_data          registered payload to WB
//   flush                       kill every held entry at this edge
//   stall_cnt                   saturating count of out_valid & !out_ready cycles
// SKID=1 gives a registered in_ready backed by a one-entry skid slot;
// SKID=0 gives a combinational in_ready with no extra storage.
module wb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              m_free_s;
  logic              m_load_s;
  logic              m_unload_s;
  logic [CTRL_W-1:0] m_src_ctrl_s;
  logic [DATA_W-1:0] m_src_data_s;
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Handshake decode and main-register load control. An input arriving in a
  // flush cycle is discarded, so it never counts as a transfer.
  always_comb begin
    in_xfer_s  = in_valid & in_ready & ~flush;
    out_xfer_s = out_valid & out_ready;
    m_free_s   = ~out_valid | out_ready;
    m_load_s   = m_free_s & (skid_valid_s | in_xfer_s);
    m_unload_s = out_xfer_s & ~m_load_s;
    // The skid slot always holds older data than the current input.
    if (skid_valid_s) begin
      m_src_ctrl_s = skid_ctrl_s;
      m_src_data_s = skid_data_s;
    end else begin
      m_src_ctrl_s = in_ctrl;
      m_src_data_s = in_data;
    end
  end

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .load    (m_load_s),
    .unload  (m_unload_s),
    .d_ctrl  (m_src_ctrl_s),
    .d_data  (m_src_data_s),
    .q_valid (out_valid),
    .q_ctrl  (out_ctrl),
    .q_data  (out_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load_s;
      logic skid_unload_s;

      // Park an accepted input when M is busy and not draining; hand the
      // parked entry to M as soon as M frees up.
      assign skid_load_s   = in_xfer_s & ~m_free_s;
      assign skid_unload_s = m_free_s & skid_valid_s;

      pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .load    (skid_load_s),
        .unload  (skid_unload_s),
        .d_ctrl  (in_ctrl),
        .d_data  (in_data),
        .q_valid (skid_valid_s),
        .q_ctrl  (skid_ctrl_s),
        .q_data  (skid_data_s)
      );

      // Straight from a flop, so out_ready never reaches in_ready.
      assign in_ready = ~skid_valid_s;
    end else begin : g_noskid
      assign skid_valid_s = 1'b0;
      assign skid_ctrl_s  = '0;
      assign skid_data_s  = '0;
      assign in_ready     = out_ready | ~out_valid;
    end
  endgenerate

  // Back-pressure counter: saturates at all-ones, frozen during flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (flush) begin
      stall_cnt_r <= stall_cnt_r;
    end else if (out_valid & ~out_ready & (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_wb_pipe_stage.sv
module tb_wb_pipe_stage;

  localparam int CW = 3;
  localparam int DW = 101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: SKID=1, instance B: SKID=0, instance C: SKID=1 with a 4-bit counter
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [15:0] a_stall;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [15:0] b_stall;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
  logic [CW-1:0] c_in_ctrl, c_out_ctrl;
  logic [DW-1:0] c_in_data, c_out_data;
  logic [3:0] c_stall;

  wb_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .flush(a_flush), .stall_cnt(a_stall));

  wb_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .flush(b_flush), .stall_cnt(b_stall));

  wb_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
    .flush(c_flush), .stall_cnt(c_stall));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       iv, ordy, fl;
    logic [2:0] ic;
    logic [7:0] id;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] ed;
    logic       erdy;
    logic [15:0] es;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input logic iv, ordy, fl, input logic [2:0] ic, input logic [7:0] id,
                      input logic ev, input logic [2:0] ec, input logic [7:0] ed,
                      input logic erdy, input logic [15:0] es);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ic = ic; v.id = id;
    v.ev = ev; v.ec = ec; v.ed = ed; v.erdy = erdy; v.es = es;
    tbl.push_back(v);
  endtask

  // Reference model for the random phase: a FIFO of in-flight payloads
  typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } item_t;
  item_t qa[$];
  item_t qb[$];
  logic [15:0] sa, sb;

  initial begin
    rst_n = 1'b0;
    {a_in_valid, a_out_ready, a_flush, a_in_ctrl, a_in_data} = '0;
    {b_in_valid, b_out_ready, b_flush, b_in_ctrl, b_in_data} = '0;
    {c_in_valid, c_out_ready, c_flush, c_in_ctrl, c_in_data} = '0;

    // Streaming 0..7
    for (int k = 0; k < 8; k++)
      addv(1'b1, 1'b1, 1'b0, 3'(k), 8'(k), 1'b1, 3'(k), 8'(k), 1'b1, 16'd0);
    addv(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 8'h07, 1'b1, 16'd0);
    // Back-pressure: A held, B in skid
    addv(1'b1, 1'b0, 1'b0, 3'd1, 8'h0A, 1'b1, 3'd1, 8'h0A, 1'b1, 16'd0);
    addv(1'b1, 1'b0, 1'b0, 3'd2, 8'h0B, 1'b1, 3'd1, 8'h0A, 1'b0, 16'd1);
    addv(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h0A, 1'b0, 16'd2);
    addv(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h0A, 1'b0, 16'd3);
    addv(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h0A, 1'b0, 16'd4);
    addv(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h0B, 1'b1, 16'd4);
    addv(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 8'h0B, 1'b1, 16'd4);
    // Flush with full skid, C presented while not ready, then D
    addv(1'b1, 1'b0, 1'b0, 3'd5, 8'h1A, 1'b1, 3'd5, 8'h1A, 1'b1, 16'd4);
    addv(1'b1, 1'b0, 1'b0, 3'd6, 8'h1B, 1'b1, 3'd5, 8'h1A, 1'b0, 16'd5);
    addv(1'b1, 1'b0, 1'b1, 3'd4, 8'h1C, 1'b0, 3'd0, 8'h1A, 1'b1, 16'd5);
    addv(1'b1, 1'b1, 1'b0, 3'd3, 8'h1D, 1'b1, 3'd3, 8'h1D, 1'b1, 16'd5);
    addv(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 8'h1D, 1'b1, 16'd5);
    // Flush while ready: the concurrent input is discarded
    addv(1'b1, 1'b0, 1'b1, 3'd7, 8'h2E, 1'b0, 3'd0, 8'h1D, 1'b1, 16'd5);
    addv(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h1D, 1'b1, 16'd5);

    // Reset state
    @(negedge clk);
    chk("rst out_valid", a_out_valid, 1'b0);
    chk("rst out_ctrl", a_out_ctrl, 3'd0);
    chk("rst out_data", a_out_data, '0);
    chk("rst stall", a_stall, 16'd0);
    chk("rst in_ready skid", a_in_ready, 1'b1);
    chk("rst in_ready noskid", b_in_ready, 1'b1);
    rst_n = 1'b1;

    // Table phase on instance A
    foreach (tbl[i]) begin
      a_in_valid = tbl[i].iv; a_out_ready = tbl[i].ordy; a_flush = tbl[i].fl;
      a_in_ctrl = tbl[i].ic; a_in_data = DW'(tbl[i].id);
      @(negedge clk);
      chk($sformatf("row%0d out_valid", i), a_out_valid, tbl[i].ev);
      chk($sformatf("row%0d out_ctrl", i), a_out_ctrl, tbl[i].ec);
      chk($sformatf("row%0d out_data", i), a_out_data, tbl[i].ed);
      chk($sformatf("row%0d in_ready", i), a_in_ready, tbl[i].erdy);
      chk($sformatf("row%0d stall", i), a_stall, tbl[i].es);
    end
    a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;

    // Reset mid-stream
    a_in_valid = 1'b1; a_in_ctrl = 3'b101; a_in_data = DW'(8'h55);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-rst out_valid", a_out_valid, 1'b1);
    chk("pre-rst out_ctrl", a_out_ctrl, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", a_out_valid, 1'b0);
    chk("async rst out_ctrl", a_out_ctrl, 3'd0);
    chk("async rst stall", a_stall, 16'd0);
    chk("async rst in_ready", a_in_ready, 1'b1);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // SKID=0: combinational in_ready
    b_in_valid = 1'b1; b_in_ctrl = 3'd1; b_in_data = DW'(8'h21); b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("noskid loaded", b_out_valid, 1'b1);
    #1 chk("noskid in_ready low", b_in_ready, 1'b0);
    b_out_ready = 1'b1;
    #1 chk("noskid in_ready high", b_in_ready, 1'b1);
    b_in_valid = 1'b1; b_in_ctrl = 3'd2; b_in_data = DW'(8'h22);
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("noskid same-edge valid", b_out_valid, 1'b1);
    chk("noskid same-edge data", b_out_data, 8'h22);
    chk("noskid same-edge ctrl", b_out_ctrl, 3'd2);
    @(negedge clk);
    chk("noskid drained", b_out_valid, 1'b0);
    b_out_ready = 1'b0;

    // Counter saturation on 4-bit instance
    c_in_valid = 1'b1; c_in_ctrl = 3'd6; c_in_data = DW'(8'h33); c_out_ready = 1'b0;
    @(negedge clk);
    c_in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("sat stall 14", c_stall, 4'd14);
    repeat (6) @(negedge clk);
    chk("sat stall 15", c_stall, 4'd15);
    chk("sat hold data", c_out_data, 8'h33);
    chk("sat hold ctrl", c_out_ctrl, 3'd6);
    chk("sat in_ready", c_in_ready, 1'b1);
    chk("sat valid", c_out_valid, 1'b1);

    // Random phase on A and B against the FIFO model
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    sa = 16'd0; sb = 16'd0;
    for (int n = 0; n < 400; n++) begin
      logic iv, ordy, fl, ra, rb;
      logic [127:0] rnd;
      item_t it;
      chk("rnd A valid", a_out_valid, qa.size() != 0);
      if (qa.size() != 0) begin
        chk("rnd A ctrl", a_out_ctrl, qa[0].c);
        chk("rnd A data", a_out_data, qa[0].d);
      end
      chk("rnd A stall", a_stall, sa);
      chk("rnd B valid", b_out_valid, qb.size() != 0);
      if (qb.size() != 0) begin
        chk("rnd B ctrl", b_out_ctrl, qb[0].c);
        chk("rnd B data", b_out_data, qb[0].d);
      end
      chk("rnd B stall", b_stall, sb);

      iv = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      it.c = CW'($urandom);
      it.d = rnd[DW-1:0];
      a_in_valid = iv; a_out_ready = ordy; a_flush = fl; a_in_ctrl = it.c; a_in_data = it.d;
      b_in_valid = iv; b_out_ready = ordy; b_flush = fl; b_in_ctrl = it.c; b_in_data = it.d;
      #1;
      ra = (qa.size() < 2);
      rb = (qb.size() == 0) || ordy;
      chk("rnd A in_ready", a_in_ready, ra);
      chk("rnd B in_ready", b_in_ready, rb);

      if (!fl && qa.size() != 0 && !ordy && sa != 16'hFFFF) sa++;
      if (!fl && qb.size() != 0 && !ordy && sb != 16'hFFFF) sb++;
      if (fl) begin
        qa.delete();
        qb.delete();
      end else begin
        if (qa.size() != 0 && ordy) void'(qa.pop_front());
        if (iv && ra) qa.push_back(it);
        if (qb.size() != 0 && ordy) void'(qb.pop_front());
        if (iv && rb) qb.push_back(it);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Parametrised elastic pipeline register for the memory-to-writeback boundary, and the successor to the fixed-width, always-enabled stage register.
- Carries a payload split into a control field and a data field.
- Adds a valid/ready handshake, an optional 1-entry skid buffer, a flush that kills in-flight control, asynchronous reset, and a saturating back-pressure counter.
- Sits between the MEM stage and the register-file write port; also usable at any other stage boundary.

Parameters:
CTRL_W, 3, control bits (RegWrite, ResultSrc[1:0]); forced to zero on flush/reset
DATA_W, 101, data bits (ReadData, ALUResult, PCPlus4, Rd)
SKID, 1, 1 = registered in_ready with 1-entry skid buffer; 0 = combinational in_ready, no skid
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream data field
out_valid  out  1  payload valid to WB
out_ready  in  1  WB accepts
out_ctrl  out  CTRL_W  control to WB
out_data  out  DATA_W  data to WB
flush  in  1  kill all held entries this edge
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_ctrl=0, out_data=0, skid entry empty with zeroed fields, stall_cnt=0. in_ready=1 after reset in both modes.
- Transfers: input transfer when in_valid & in_ready at a rising edge; output transfer when out_valid & out_ready at a rising edge. Latency is 1 cycle from input transfer to out_valid.
- Main register (M) drives the out_* ports.
  - M loads when empty, or when its content transfers out in the same cycle.
  - Source is the skid entry if occupied, else the input.
- SKID=1:
  - in_ready = !skid_full (registered).
  - An input accepted while M is occupied and not draining goes to the skid entry.
  - When M drains and skid is full: skid moves to M and in_ready rises next cycle.
  - Full-rate throughput with out_ready=1.
  - Order is preserved: skid data always precedes new input.
- SKID=0: in_ready = out_ready | !out_valid (combinational); no skid storage.
- Flush (flush=1 at a rising edge):
  - Clears out_valid and skid_full.
  - Zeroes out_ctrl and the skid ctrl; data fields hold.
  - Any concurrent input transfer is discarded.
  - An output transfer with out_ready=1 in the flush cycle still counts as consumed by WB (payload was visible before the edge).
  - in_ready is 1 in the cycle after a flush.
- Priority: rst_n > flush > normal load.
- Stall counter:
  - Increments when out_valid & !out_ready; saturates at all-ones.
  - Does not count during a flush cycle. Cleared only by reset.
- Hold rule: while out_valid=1 and out_ready=0, out_ctrl/out_data stay stable.
- No combinational path from in_* to out_* in either mode.
- SKID=1: no combinational path from out_ready to in_ready.

Decomposition:
- Shared package (pipe_pkg):
  - Default widths CTRL_W/DATA_W for the MEM/WB boundary.
  - Bit-field offsets for RegWrite, ResultSrc, ReadData, ALUResult, PCPlus4, Rd within the packed payload.
  - ResultSrc encodings.
- One natural sub-module: pipe_skid_entry (one ctrl+data slot with valid, flush clear and load enable), instantiated for M and, when SKID=1, for the skid slot.
- The counter stays inline.

Test Plan:
- Reset mid-stream: pulse rst_n low with out_valid=1, ctrl=3'b101 → out_valid=0, out_ctrl=0, stall_cnt=0 immediately (before the next edge); in_ready=1.
- Streaming, SKID=1, out_ready=1: 8 back-to-back inputs with data=0..7 → outputs 0..7 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Back-pressure, SKID=1:
  - Drive out_ready=0 for 4 cycles while inputs A, B arrive → A held on out, B in skid, in_ready=0, stall_cnt=4.
  - Release out_ready → A then B, in order, no loss/duplication.
- Flush with full skid: A in M, B in skid, C presented, flush=1 → next cycle out_valid=0, out_ctrl=0, C dropped, in_ready=1; subsequent D emerges next.
- SKID=0 instance: out_ready=0 with out_valid=1 → in_ready=0 same cycle; out_ready=1 → in_ready=1 same cycle, new input loads on that edge.
- Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15.
